// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and byte classification for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bytes that follow E1 in the Pause make/break sequence.
  localparam int PS2_PAUSE_LEN = 7;

  // Keyboard replies to host commands; never key codes when no prefix is pending.
  localparam int PS2_NUM_HOST = 6;
  localparam logic [7:0] PS2_HOST_RESP [PS2_NUM_HOST] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXTBRK,
    ST_SKIP
  } state_t;

  function automatic logic is_host_resp(input logic [7:0] b);
    logic hit;
    // NOTE: give every variable a value before any conditional write so no latch/hold is implied.
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_HOST; i++) begin
      if (b == PS2_HOST_RESP[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame receiver: synchronizes and filters
// both lines, samples data on filtered clock falls, checks start/parity/stop,
// and discards a stalled partial frame after TIMEOUT idle cycles.
module ps2_rx_frame #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] data
);

  localparam int FW = ($clog2(FILTER) < 1) ? 1 : $clog2(FILTER);
  localparam int WW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_c_q;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [WW-1:0] wd;
  logic          frame_ok;

  assign raw = {ps2d, ps2c};

  // Two-flop synchronizer, then accept a new level only after FILTER equal samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      filt  <= '1;
      // NOTE: this is a two-entry register array, not a RAM, so it is reset like any flop.
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Falling-edge detector on the filtered clock line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) filt_c_q <= 1'b1;
    else       filt_c_q <= filt[0];
  end

  assign fall = filt_c_q & ~filt[0];

  // shreg[0] = start, shreg[8:1] = data LSB first, shreg[9] = parity; filt[1] is the stop bit here.
  assign frame_ok = ~shreg[0] & filt[1] & (^shreg[9:1]);

  // Bit collection, frame completion and mid-frame watchdog; a clock fall beats a timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      wd         <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      data       <= '0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (fall) begin
        wd <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          data       <= shreg[8:1];
          byte_valid <= frame_ok;
          byte_err   <= ~frame_ok;
        end else begin
          shreg   <= {filt[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt == 4'd0) begin
        wd <= '0;
      end else if (wd == WW'(TIMEOUT - 1)) begin
        wd      <= '0;
        bit_cnt <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_decoder.sv
// PS/2 set-2 scancode decoder: strips F0/E0 prefixes and the Pause sequence,
// drops host replies, and emits one strobe per key event with an active-low press flag.
module ps2_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext
);

  logic       byte_valid;
  logic       byte_err;
  logic [7:0] data;
  state_t     state;
  logic [2:0] skip_cnt;

  ps2_rx_frame #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .data      (data)
  );

  // Prefix state machine with registered strobe and held code/make/ext outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      strb     <= 1'b0;
      make     <= 1'b1;
      code     <= '0;
      ext      <= 1'b0;
    end else begin
      strb <= 1'b0;
      if (byte_err) begin
        state    <= ST_IDLE;
        skip_cnt <= '0;
      end else if (byte_valid) begin
        if (state == ST_SKIP) begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= ST_IDLE;
        end else if (data == PS2_BRK) begin
          state <= (state == ST_EXT || state == ST_EXTBRK) ? ST_EXTBRK : ST_BRK;
        end else if (data == PS2_EXT) begin
          state <= (state == ST_BRK || state == ST_EXTBRK) ? ST_EXTBRK : ST_EXT;
        end else if (data == PS2_PAUSE) begin
          state    <= ST_SKIP;
          skip_cnt <= 3'(PS2_PAUSE_LEN);
        end else if (state == ST_IDLE && is_host_resp(data)) begin
          state <= ST_IDLE;
        end else begin
          strb  <= 1'b1;
          code  <= data;
          make  <= (state == ST_BRK) || (state == ST_EXTBRK);
          ext   <= (state == ST_EXT) || (state == ST_EXTBRK);
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_decoder.sv
// Self-checking bench for ps2_decoder: table of byte sequences with hand-derived
// strobes, hand-written latency/timeout/glitch/reset sequences, and a random
// byte stream checked against a flag-based reference model.
module tb_ps2_decoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 20;
  localparam int GAP     = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       strb;
  logic       make;
  logic [7:0] code;
  logic       ext;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int strb_cyc = -1;

  // Strobe records are {make, ext, code}.
  logic [9:0] got  [$];
  logic [9:0] expq [$];

  // Reference model state: pending release/extended flags and Pause bytes left to swallow.
  bit m_brk;
  bit m_ext;
  int m_skip;

  typedef struct {
    int          n;
    logic [71:0] bytes;
    logic [8:0]  bad;
    int          ne;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [6];

  ps2_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .strb (strb),
    .make (make),
    .code (code),
    .ext  (ext)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (strb === 1'b1) begin
      got.push_back({make, ext, code});
      strb_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      if (i == 10) fall_cyc = cyc;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic compare_q(input string name);
    check({name, " count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check($sformatf("%s strobe%0d", name, i), {22'd0, got[i]}, {22'd0, expq[i]});
    got.delete();
    expq.delete();
  endtask

  function automatic bit model_host(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_brk = 0; m_ext = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_brk = 0; m_ext = 0;
    end else if (!m_brk && !m_ext && model_host(b)) begin
      m_brk = 0;
    end else begin
      expq.push_back({m_brk, m_ext, b});
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
  endtask

  initial begin
    logic [7:0] b;
    bit         bad;
    int         r;

    vecs[0] = '{2, 72'h1C_F0, 9'h000, 1, 20'h0021C};
    vecs[1] = '{5, 72'h75_F0_E0_75_E0, 9'h000, 2, {10'h375, 10'h175}};
    vecs[2] = '{3, 72'h29_29_F0, 9'h002, 1, 20'h00029};
    vecs[3] = '{9, 72'h12_77_F0_14_F0_E1_77_14_E1, 9'h000, 1, 20'h00012};
    vecs[4] = '{7, 72'h1C_FF_00_FE_EE_FA_AA, 9'h000, 1, 20'h0001C};
    vecs[5] = '{2, 72'h12_E0, 9'h000, 1, 20'h00112};

    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    wait_cyc(3);
    check("reset strb", {31'd0, strb}, 32'd0);
    check("reset make", {31'd0, make}, 32'd1);
    check("reset code", {24'd0, code}, 32'h00);
    check("reset ext",  {31'd0, ext},  32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Single frame 1C and its latency from the stop-bit clock fall.
    send_bits(8'h1C, 1'b0, 11);
    expq.push_back(10'h01C);
    compare_q("frame_1C");
    check("latency", strb_cyc - fall_cyc, FILTER + 4);

    // Table of byte sequences with hand-derived strobes.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        send_bits(vecs[v].bytes[8*i +: 8], vecs[v].bad[i], 11);
      for (int k = 0; k < vecs[v].ne; k++)
        expq.push_back(vecs[v].exp[10*k +: 10]);
      compare_q($sformatf("vec%0d", v));
    end

    // Stalled partial frame is discarded by the watchdog; the F0 before it survives.
    send_bits(8'hF0, 1'b0, 11);
    send_bits(8'h33, 1'b0, 6);
    wait_cyc(TIMEOUT + 10);
    send_bits(8'h5A, 1'b0, 11);
    expq.push_back(10'h25A);
    compare_q("timeout");

    // A 3-cycle low glitch on the clock line must not register as a bit.
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(GAP);
    send_bits(8'h1C, 1'b0, 11);
    expq.push_back(10'h01C);
    compare_q("glitch");

    // Reset in the middle of a frame, then a full frame decodes cleanly.
    send_bits(8'hF0, 1'b0, 11);
    send_bits(8'h44, 1'b0, 5);
    reset = 1'b1;
    #1;
    check("midreset strb", {31'd0, strb}, 32'd0);
    check("midreset make", {31'd0, make}, 32'd1);
    check("midreset code", {24'd0, code}, 32'h00);
    check("midreset ext",  {31'd0, ext},  32'd0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(GAP);
    send_bits(8'h6B, 1'b0, 11);
    expq.push_back(10'h06B);
    compare_q("after_reset");

    // Random byte stream against the reference model.
    do_reset();
    m_brk = 0; m_ext = 0; m_skip = 0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0:       b = 8'hF0;
        1:       b = 8'hE0;
        2:       b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h16;
        3:       b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = (m_skip == 0) && ($urandom_range(0, 9) == 0);
      model_byte(b, bad);
      send_bits(b, bad, 11);
    end
    compare_q("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
